stream_program_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 22 ++
 rtl/xor_checksum8.sv | 24 ++
 rtl/stream_program_loader.sv | 136 +++++++++++++
 tb/tb_stream_program_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the streamed program loader.
package loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } load_state_t;

   // Length and data words both arrive most-significant byte first.
   localparam bit FRAME_HI_FIRST = 1'b1;

   localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0000;
   localparam int unsigned DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/xor_checksum8.sv
// Running XOR of accepted frame bytes; updates one cycle after enable.
// Clear wins over enable so a new load starts from 8'h00.
module xor_checksum8
   import loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] data,
   output logic [7:0] acc
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc ^ data;
      end
   end

endmodule

// File: rtl/stream_program_loader.sv
// Framed byte-stream loader: LEN_HI LEN_LO {word hi, lo}* CHK -> sequential RAM writes.
// Three cycles per word minimum; in_ready drops in WRITE/IDLE/DONE/ERROR, source stalls hold state.
module stream_program_loader
   import loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_write_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count
);

   load_state_t state;
   logic [15:0] length;
   logic [7:0]  first_byte;
   logic [7:0]  chk_acc;
   logic        take;
   logic        at_rest;
   logic [15:0] new_length;

   assign take       = in_valid && in_ready;
   assign at_rest    = (state == IDLE) || (state == DONE) || (state == ERROR);
   assign new_length = {length[15:8], in_data};

   // CHK itself is never folded in; it is compared against the accumulator.
   xor_checksum8 u_checksum (
      .clock  (clock),
      .reset  (reset),
      .clear  (start && at_rest),
      .enable (take && (state != CHECK)),
      .data   (in_data),
      .acc    (chk_acc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         length         <= '0;
         first_byte     <= '0;
         in_ready       <= 1'b0;
         mem_write      <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         word_count     <= '0;
      end else begin
         mem_write <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state      <= LEN_HI;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  word_count <= '0;
               end
            end
            LEN_HI: begin
               if (take) begin
                  length[15:8] <= in_data;
                  state        <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (take) begin
                  length[7:0] <= in_data;
                  if (32'(new_length) > MAX_WORDS) begin
                     state    <= ERROR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else if (new_length == 16'd0) begin
                     state <= CHECK;
                  end else begin
                     state <= DATA_HI;
                  end
               end
            end
            DATA_HI: begin
               if (take) begin
                  first_byte <= in_data;
                  state      <= DATA_LO;
               end
            end
            DATA_LO: begin
               if (take) begin
                  mem_write_data <= FRAME_HI_FIRST ? {first_byte, in_data}
                                                   : {in_data, first_byte};
                  mem_addr       <= BASE_ADDR + word_count;
                  mem_write      <= 1'b1;
                  in_ready       <= 1'b0;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               word_count <= word_count + 16'd1;
               in_ready   <= 1'b1;
               state      <= (word_count + 16'd1 == length) ? CHECK : DATA_HI;
            end
            CHECK: begin
               if (take) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == chk_acc) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_program_loader.sv
// Directed bench for stream_program_loader: good/bad checksums, length limits, stalls, reset mid-load.
module tb_stream_program_loader;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        start    = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data  = 8'h00;
   logic        in_ready;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_write_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] word_count;

   int errors = 0;
   int checks = 0;

   int          n_accepted       = 0;
   int          n_ready_in_write = 0;
   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];

   always #5 clock = ~clock;

   stream_program_loader dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .word_count     (word_count)
   );

   // Falling-edge monitor: records RAM writes and byte handshakes.
   always @(negedge clock) begin
      if (mem_write) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_write_data);
      end
      if (in_valid && in_ready) n_accepted++;
      if (mem_write && in_ready) n_ready_in_write++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) begin
         in_valid = 1'b0;
         @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (n < 50) begin
         @(negedge clock);
         if (in_ready) break;
         n++;
      end
      check("in_ready_wait", 32'(n < 50), 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
      foreach (fr[i]) send_byte(fr[i], gaps ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic check_writes(input string tag, input int base,
                               input logic [31:0] ea[$], input logic [31:0] ed[$]);
      logic [31:0] oa, od;
      check({tag, "_wr_count"}, 32'(wr_addr.size() - base), 32'(ea.size()));
      foreach (ea[k]) begin
         oa = (base + k < wr_addr.size()) ? 32'(wr_addr[base + k]) : 32'hFFFF_FFFF;
         od = (base + k < wr_data.size()) ? 32'(wr_data[base + k]) : 32'hFFFF_FFFF;
         check($sformatf("%s_addr%0d", tag, k), oa, ea[k]);
         check($sformatf("%s_data%0d", tag, k), od, ed[k]);
      end
   endtask

   initial begin
      logic [7:0]  fr[$];
      logic [7:0]  big[$];
      logic [7:0]  chk;
      logic [31:0] ea[$];
      logic [31:0] ed[$];
      int          base;
      int          acc0;
      int          rw0;

      // Reset state, checked while reset is held and after release.
      repeat (3) @(posedge clock);
      #1;
      check("rst_outputs_held",
            32'({in_ready, mem_write, busy, done, error}), 0);
      check("rst_addr_data", {mem_addr, mem_write_data}, 0);
      reset = 1'b0;
      @(posedge clock); #1;
      check("idle_word_count", 32'(word_count), 0);
      check("idle_in_ready", 32'(in_ready), 0);

      // Three-word frame, source always valid. XOR of 00 03 12 34 AB CD 00 07 is 0x44.
      ea = '{32'h0, 32'h1, 32'h2};
      ed = '{32'h1234, 32'hABCD, 32'h0007};
      fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'h44};
      base = wr_addr.size(); acc0 = n_accepted; rw0 = n_ready_in_write;
      pulse_start();
      check("a_busy_after_start", 32'({busy, in_ready}), 32'b11);
      send_frame(fr, 1'b0);
      check("a_done_error_busy", 32'({done, error, busy}), 32'b100);
      check("a_word_count", 32'(word_count), 3);
      check("a_accepted", 32'(n_accepted - acc0), 9);
      check("a_ready_in_write", 32'(n_ready_in_write - rw0), 0);
      check_writes("a", base, ea, ed);

      // Start from DONE clears status and count.
      pulse_start();
      check("restart_clear", 32'({done, error, busy, in_ready}), 32'b0011);
      check("restart_word_count", 32'(word_count), 0);

      // Same frame, wrong checksum: writes still land, then error.
      fr[8] = 8'h5D;
      base = wr_addr.size();
      send_frame(fr, 1'b0);
      check("b_done_error_busy", 32'({done, error, busy}), 32'b010);
      check("b_word_count", 32'(word_count), 3);
      check_writes("b", base, ea, ed);

      // Length 0x0101 exceeds the limit: error right after LEN_LO, no writes.
      base = wr_addr.size();
      pulse_start();
      fr = '{8'h01, 8'h01};
      send_frame(fr, 1'b0);
      check("c_error_after_len", 32'({done, error, busy, in_ready}), 32'b0100);
      in_valid = 1'b1; in_data = 8'h12;
      repeat (6) @(posedge clock);
      #1;
      in_valid = 1'b0;
      check("c_no_writes", 32'(wr_addr.size() - base), 0);
      check("c_still_error", 32'({done, error}), 32'b01);

      // Zero length, matching checksum.
      base = wr_addr.size();
      pulse_start();
      fr = '{8'h00, 8'h00, 8'h00};
      send_frame(fr, 1'b0);
      check("d_zero_len_done", 32'({done, error}), 32'b10);
      check("d_no_writes", 32'(wr_addr.size() - base), 0);

      // Zero length, bad checksum.
      pulse_start();
      fr = '{8'h00, 8'h00, 8'h01};
      send_frame(fr, 1'b0);
      check("e_zero_len_error", 32'({done, error}), 32'b01);

      // Three-word frame again with random source gaps.
      fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'h44};
      base = wr_addr.size(); acc0 = n_accepted; rw0 = n_ready_in_write;
      pulse_start();
      send_frame(fr, 1'b1);
      check("f_done_error", 32'({done, error}), 32'b10);
      check("f_accepted", 32'(n_accepted - acc0), 9);
      check("f_ready_in_write", 32'(n_ready_in_write - rw0), 0);
      check_writes("f", base, ea, ed);

      // Exactly MAX_WORDS words is accepted; word i = {i ^ A5, i}.
      big = '{8'h01, 8'h00};
      chk = 8'h01;
      for (int i = 0; i < 256; i++) begin
         big.push_back(8'(i) ^ 8'hA5);
         big.push_back(8'(i));
         chk = chk ^ 8'(i) ^ 8'hA5 ^ 8'(i);
      end
      big.push_back(chk);
      base = wr_addr.size();
      pulse_start();
      send_frame(big, 1'b0);
      check("g_done_error", 32'({done, error}), 32'b10);
      check("g_word_count", 32'(word_count), 256);
      check("g_wr_count", 32'(wr_addr.size() - base), 256);
      check("g_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'h00FF);
      check("g_last_data", 32'(wr_data[wr_data.size() - 1]), 32'h5AFF);

      // Reset after the second write abandons the frame.
      base = wr_addr.size();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("h_start_ignored_busy", 32'({busy, in_ready, done, error}), 32'b1100);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      @(posedge clock); #1;
      check("h_count_before_reset", 32'(word_count), 2);
      #2;
      reset = 1'b1;
      #1;
      check("h_async_outputs", 32'({in_ready, mem_write, busy, done, error}), 0);
      check("h_async_addr_data", {mem_addr, mem_write_data}, 0);
      check("h_async_word_count", 32'(word_count), 0);
      in_valid = 1'b1; in_data = 8'h77;
      repeat (2) @(posedge clock);
      #1;
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      check("h_idle_after_reset", 32'({busy, in_ready, done, error}), 0);
      ea = '{32'h0, 32'h1};
      ed = '{32'h1234, 32'hABCD};
      check_writes("h", base, ea, ed);

      // Fresh one-word frame after reset.
      base = wr_addr.size();
      pulse_start();
      fr = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
      send_frame(fr, 1'b0);
      check("i_done_error", 32'({done, error}), 32'b10);
      check("i_word_count", 32'(word_count), 1);
      ea = '{32'h0};
      ed = '{32'hBEEF};
      check_writes("i", base, ea, ed);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
